lc3b_core_param: RTL
====================

// Module: lc3b_core_param
// PURPOSE
//  Multicycle LC-3b core: datapath with integrated microsequencer. Adds sync reset, imm5 ALU mode,
//  a req/resp memory handshake with timeout, and retire/illegal/timeout status pulses.
//  Sits between the memory model and the testbench; executes ADD/AND/NOT/LDR/STR/BR.
// PARAMETERS
//  RESET_PC      16'h0000  PC value loaded on reset
//  EN_IMM5       1         1: IR[5]=1 selects sext(IR[4:0]) as ALU b for ADD/AND; 0: IR[5] ignored
//  MEM_WAIT_MAX  0         max wait cycles per memory access before abort; 0 = wait forever
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  mem_rdata      in   16  read data, valid in the cycle mem_resp=1 during a read
//  mem_resp       in   1   memory completion; ignored unless mem_read or mem_write is high
//  mem_address    out  16  MAR contents
//  mem_wdata      out  16  MDR contents
//  mem_read       out  1   read request, held until completion or abort
//  mem_write      out  1   write request, held until completion or abort
//  insn_retire    out  1   1-cycle pulse in the final cycle of each completed instruction
//  illegal_op     out  1   1-cycle pulse in DECODE for an unsupported opcode
//  mem_timeout    out  1   1-cycle pulse in the cycle an access is aborted
// BEHAVIOUR
//  Reset: PC=RESET_PC; IR, MAR, MDR, R0-R7 = 0; CC=3'b010; state FETCH1; all outputs 0 after the edge.
//   Reset mid-access drops mem_read/mem_write at that edge. No partial arch update is kept.
//  States and transitions:
//   FETCH1 -> FETCH2: MAR<=PC.
//   FETCH2: mem_read=1. On mem_resp: MDR<=mem_rdata, go FETCH3.
//   FETCH3 -> DECODE: IR<=MDR; PC<=PC+2.
//   DECODE: ADD/AND/NOT -> ALU; LDR/STR -> CALC; BR -> BR.
//    Other opcodes: illegal_op=1 -> FETCH1. This retires nothing.
//   ALU -> FETCH1: DR<=result; CC<=gencc(result); insn_retire=1.
//    ADD/AND use b = SR2 or sext(imm5). NOT is ~SR1.
//   CALC -> LDR1|STR1: MAR<=SR1 + (sext(IR[5:0])<<1).
//   LDR1: mem_read=1. On resp: MDR<=rdata, go LDR2.
//   LDR2 -> FETCH1: DR<=MDR; CC<=gencc(MDR); insn_retire=1.
//   STR1 -> STR2: MDR<=R[IR[11:9]].
//   STR2: mem_write=1. On resp -> FETCH1 with insn_retire=1. CC unchanged.
//   BR -> FETCH1: if |(IR[11:9] & CC), PC<=PC + (sext(IR[8:0])<<1). insn_retire=1.
//    nzp=000 is never taken.
//  gencc: n = bit15; z = (value==0); p otherwise. Exactly one bit is set.
//  Arithmetic: all adds are 16-bit and wrap mod 2^16 (PC+2 at 16'hFFFE gives 16'h0000).
//  Handshake: the request is high from the first cycle of the wait state.
//   mem_resp in that same cycle is a 0-wait completion. Data is captured on that edge.
//   The request deasserts on the next cycle.
//  Timeout (MEM_WAIT_MAX>0): wait_cnt clears on entry to each wait state.
//   Abort when wait_cnt==MEM_WAIT_MAX with no resp: mem_timeout=1, drop request, go FETCH1, no retire.
//   A fetch abort refetches the same PC, because PC is not yet incremented.
//   An LDR abort leaves DR/CC unchanged. An STR abort leaves memory undefined.
//  Latency with 0-wait memory: ALU/BR 5 cycles, LDR/STR 7 cycles (FETCH1 to retire, inclusive).
//  Regfile write and read of the same register in one cycle: the read returns the old value.
// STRUCTURE
//  lc3b_types package: lc3b_word, lc3b_reg, lc3b_nzp, lc3b_offset6/9, lc3b_imm5, lc3b_opcode enum,
//   plus new lc3b_ctrl_state enum.
//  Sub-module lc3b_ctrl: state register, wait counter, and per-state load/mux/mem control decode.
//  Datapath registers, ALU and regfile stay in this module.
// TESTING
//  T1 reset: rst=1 with PC mid-fetch -> next cycle mem_read=0, mem_address=0, and the next fetch uses RESET_PC.
//  T2 ALU: mem[0]=16'h1261 (ADD R1,R1,#1), R1=16'h7FFF -> R1=16'h8000, CC=100, retire at cycle 5.
//   16'h5260 (AND R1,R1,#0) -> R1=0, CC=010.
//  T3 LDR/STR: R2=16'h0100, STR R3=16'hBEEF,R2,#2 -> write addr 16'h0104 data 16'hBEEF.
//   Then LDR R4,R2,#2 -> R4=16'hBEEF, CC=100.
//  T4 BR: CC=010. BRz #-1 at PC 16'h0010 -> PC=16'h0010 (self-loop).
//   BRn at the same PC -> PC=16'h0012. nzp=000 is never taken.
//  T5 waits/timeout: resp after 3 waits -> retire cycle shifts by 3.
//   MEM_WAIT_MAX=4 with no resp -> mem_timeout pulse, request dropped, refetch of the same PC.
//  T6 illegal: opcode 4'b1101 -> illegal_op pulse, no retire, PC advanced by 2, regs/CC unchanged.

Source files
------------

// File: rtl/lc3b_core_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3b_types                                                           |
// | Shared LC-3b word/field types, opcodes, control states and gencc.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [2:0]  lc3b_nzp;
    typedef logic [5:0]  lc3b_offset6;
    typedef logic [8:0]  lc3b_offset9;
    typedef logic [4:0]  lc3b_imm5;

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000,
        OP_ADD = 4'b0001,
        OP_AND = 4'b0101,
        OP_LDR = 4'b0110,
        OP_STR = 4'b0111,
        OP_NOT = 4'b1001
    } lc3b_opcode;

    typedef enum logic [3:0] {
        S_FETCH1 = 4'd0,
        S_FETCH2 = 4'd1,
        S_FETCH3 = 4'd2,
        S_DECODE = 4'd3,
        S_ALU    = 4'd4,
        S_CALC   = 4'd5,
        S_LDR1   = 4'd6,
        S_LDR2   = 4'd7,
        S_STR1   = 4'd8,
        S_STR2   = 4'd9,
        S_BR     = 4'd10
    } lc3b_ctrl_state;

    function automatic lc3b_nzp gencc(input lc3b_word v);
        if (v[15])
            return 3'b100;
        else if (v == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3b_core_param_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3b_ctrl                                                            |
// | Microsequencer: state register, memory wait counter, control decode. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lc3b_ctrl
    import lc3b_types::*;
#(
    parameter int MEM_WAIT_MAX = 0
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       branch_en,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       pc_sel_br,
    output logic       load_ir,
    output logic       load_mar,
    output logic       mar_sel_calc,
    output logic       load_mdr,
    output logic       mdr_sel_reg,
    output logic       load_reg,
    output logic       reg_sel_mdr,
    output logic       load_cc,
    output logic       mem_read,
    output logic       mem_write,
    output logic       insn_retire,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int WCW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(MEM_WAIT_MAX);

    lc3b_ctrl_state   state, state_next;
    logic [WCW-1:0]   wait_cnt;
    logic             in_wait;
    logic             abort;

    assign in_wait = (state == S_FETCH2) || (state == S_LDR1) || (state == S_STR2);
    assign abort   = (MEM_WAIT_MAX != 0) && in_wait && !mem_resp && (wait_cnt == WAIT_LIM);

    // Counter is zero on entry to every wait state because it clears in all other states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH1;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if ((MEM_WAIT_MAX != 0) && in_wait && !mem_resp && !abort)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_next   = state;
        load_pc      = 1'b0;
        pc_sel_br    = 1'b0;
        load_ir      = 1'b0;
        load_mar     = 1'b0;
        mar_sel_calc = 1'b0;
        load_mdr     = 1'b0;
        mdr_sel_reg  = 1'b0;
        load_reg     = 1'b0;
        reg_sel_mdr  = 1'b0;
        load_cc      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        insn_retire  = 1'b0;
        illegal_op   = 1'b0;
        mem_timeout  = 1'b0;
        case (state)
            S_FETCH1: begin
                load_mar   = 1'b1;
                state_next = S_FETCH2;
            end
            S_FETCH2: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    load_mdr   = 1'b1;
                    state_next = S_FETCH3;
                end else if (abort) begin
                    mem_timeout = 1'b1;
                    state_next  = S_FETCH1;
                end
            end
            S_FETCH3: begin
                load_ir    = 1'b1;
                load_pc    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: state_next = S_ALU;
                    OP_LDR, OP_STR:         state_next = S_CALC;
                    OP_BR:                  state_next = S_BR;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH1;
                    end
                endcase
            end
            S_ALU: begin
                load_reg    = 1'b1;
                load_cc     = 1'b1;
                insn_retire = 1'b1;
                state_next  = S_FETCH1;
            end
            S_CALC: begin
                load_mar     = 1'b1;
                mar_sel_calc = 1'b1;
                state_next   = (opcode == OP_STR) ? S_STR1 : S_LDR1;
            end
            S_LDR1: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    load_mdr   = 1'b1;
                    state_next = S_LDR2;
                end else if (abort) begin
                    mem_timeout = 1'b1;
                    state_next  = S_FETCH1;
                end
            end
            S_LDR2: begin
                load_reg    = 1'b1;
                reg_sel_mdr = 1'b1;
                load_cc     = 1'b1;
                insn_retire = 1'b1;
                state_next  = S_FETCH1;
            end
            S_STR1: begin
                load_mdr    = 1'b1;
                mdr_sel_reg = 1'b1;
                state_next  = S_STR2;
            end
            S_STR2: begin
                mem_write = 1'b1;
                if (mem_resp) begin
                    insn_retire = 1'b1;
                    state_next  = S_FETCH1;
                end else if (abort) begin
                    mem_timeout = 1'b1;
                    state_next  = S_FETCH1;
                end
            end
            S_BR: begin
                load_pc     = branch_en;
                pc_sel_br   = 1'b1;
                insn_retire = 1'b1;
                state_next  = S_FETCH1;
            end
            default: state_next = S_FETCH1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lc3b_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc3b_core_param                                                      |
// | Multicycle LC-3b core: datapath, regfile and ALU around lc3b_ctrl.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lc3b_core_param
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter bit          EN_IMM5      = 1'b1,
    parameter int          MEM_WAIT_MAX = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic        insn_retire,
    output logic        illegal_op,
    output logic        mem_timeout
);

    lc3b_word pc, ir, mar, mdr;
    lc3b_word regs [8];
    lc3b_nzp  cc;

    logic load_pc, pc_sel_br, load_ir, load_mar, mar_sel_calc;
    logic load_mdr, mdr_sel_reg, load_reg, reg_sel_mdr, load_cc;

    lc3b_reg  dr, sr1, sr2;
    lc3b_word sr1_val, alu_b, alu_out, calc_addr, br_target, reg_in;
    logic     branch_en;

    assign dr  = ir[11:9];
    assign sr1 = ir[8:6];
    assign sr2 = ir[2:0];

    assign sr1_val   = regs[sr1];
    assign alu_b     = (EN_IMM5 && ir[5]) ? {{11{ir[4]}}, ir[4:0]} : regs[sr2];
    assign calc_addr = sr1_val + {{9{ir[5]}}, ir[5:0], 1'b0};
    assign br_target = pc + {{6{ir[8]}}, ir[8:0], 1'b0};
    assign branch_en = |(ir[11:9] & cc);
    assign reg_in    = reg_sel_mdr ? mdr : alu_out;

    always_comb begin
        alu_out = sr1_val + alu_b;
        case (ir[15:12])
            OP_AND:  alu_out = sr1_val & alu_b;
            OP_NOT:  alu_out = ~sr1_val;
            default: alu_out = sr1_val + alu_b;
        endcase
    end

    lc3b_ctrl #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .opcode       (ir[15:12]),
        .branch_en    (branch_en),
        .mem_resp     (mem_resp),
        .load_pc      (load_pc),
        .pc_sel_br    (pc_sel_br),
        .load_ir      (load_ir),
        .load_mar     (load_mar),
        .mar_sel_calc (mar_sel_calc),
        .load_mdr     (load_mdr),
        .mdr_sel_reg  (mdr_sel_reg),
        .load_reg     (load_reg),
        .reg_sel_mdr  (reg_sel_mdr),
        .load_cc      (load_cc),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .insn_retire  (insn_retire),
        .illegal_op   (illegal_op),
        .mem_timeout  (mem_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_PC;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            cc  <= 3'b010;
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else begin
            if (load_pc)
                pc <= pc_sel_br ? br_target : pc + 16'd2;
            if (load_ir)
                ir <= mdr;
            if (load_mar)
                mar <= mar_sel_calc ? calc_addr : pc;
            if (load_mdr)
                mdr <= mdr_sel_reg ? regs[dr] : mem_rdata;
            if (load_reg)
                regs[dr] <= reg_in;
            if (load_cc)
                cc <= gencc(reg_in);
        end
    end

    assign mem_address = mar;
    assign mem_wdata   = mdr;

endmodule
`default_nettype wire
